// File: rtl/masked_vec_irq_ctrl_if.sv
// Interface bundle for the masked, vectored interrupt controller.
// The master side (CPU/test driver) drives the request, mask and control lines.
// The slave side (the controller) returns the pending flag, the ISR vector
// and the register contents.
interface masked_vec_irq_ctrl_if #(
  parameter int AW = 8
);
  logic          itr_clr;
  logic          itr_en;
  logic [3:0]    itr_in;
  logic [3:0]    mask_in;
  logic          i_pending;
  logic [AW-1:0] pc_out;
  logic [3:0]    itr_reg;
  logic [3:0]    mask_reg;

  modport master (
    output itr_clr, itr_en, itr_in, mask_in,
    input  i_pending, pc_out, itr_reg, mask_reg
  );

  modport slave (
    input  itr_clr, itr_en, itr_in, mask_in,
    output i_pending, pc_out, itr_reg, mask_reg
  );
endinterface

// File: rtl/masked_vec_irq_ctrl.sv
// Masked, hardware-vectored, priority interrupt controller.
// Latches four request lines and a four-bit enable mask. The unmasked
// requests are priority-encoded, with bit 0 highest, and the winner's ISR
// address is driven to the PC.
// Optional build macro ITR_STICKY_EN: the request register accumulates
// requests (OR-in) instead of being overwritten; only itr_clr or clr
// removes them.
module masked_vec_irq_ctrl #(
  parameter int          AW        = 8,
  parameter logic [AW-1:0] ISR0_ADDR = AW'(150),
  parameter logic [AW-1:0] ISR1_ADDR = AW'(180),
  parameter logic [AW-1:0] ISR2_ADDR = AW'(220),
  parameter logic [AW-1:0] ISR3_ADDR = AW'(200)
) (
  input logic                   clk,
  input logic                   clr,
  masked_vec_irq_ctrl_if.slave  bus
);

  logic [3:0]    itr_q;
  logic [3:0]    mask_q;
  logic [3:0]    act;
  logic [1:0]    sel;
  logic          valid;
  logic [AW-1:0] vec;

  // Request and mask registers: async reset, then sync clear beats load.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      itr_q  <= 4'b0000;
      mask_q <= 4'b0000;
    end else if (bus.itr_clr) begin
      itr_q  <= 4'b0000;
      mask_q <= 4'b0000;
    end else if (bus.itr_en) begin
`ifdef ITR_STICKY_EN
      itr_q  <= itr_q | bus.itr_in;
`else
      itr_q  <= bus.itr_in;
`endif
      mask_q <= bus.mask_in;
    end
  end

  assign act = itr_q & mask_q;

  // Priority encoder: lowest set index of the active vector wins; sel=0 when idle.
  always_comb begin
    sel   = 2'b00;
    valid = |act;
    if (act[0])      sel = 2'd0;
    else if (act[1]) sel = 2'd1;
    else if (act[2]) sel = 2'd2;
    else if (act[3]) sel = 2'd3;
  end

  // Vector mux: fully decoded, falling back to the source-0 vector.
  always_comb begin
    vec = ISR0_ADDR;
    case (sel)
      2'd0:    vec = ISR0_ADDR;
      2'd1:    vec = ISR1_ADDR;
      2'd2:    vec = ISR2_ADDR;
      2'd3:    vec = ISR3_ADDR;
      default: vec = ISR0_ADDR;
    endcase
  end

  // itr_en gates the pending flag combinationally so the CPU can hold off
  // interrupts without disturbing the latched state.
  assign bus.i_pending = valid & bus.itr_en;
  assign bus.pc_out    = vec;
  assign bus.itr_reg   = itr_q;
  assign bus.mask_reg  = mask_q;

endmodule

// File: tb/tb_masked_vec_irq_ctrl.sv
// Self-checking bench for masked_vec_irq_ctrl.
// A table of vectors is applied one per clock; the expected outputs of each
// are pushed to a scoreboard queue when driven and popped after the edge.
// Hand-written sequences cover async reset, same-cycle itr_en gating and
// clr held across edges. Build with ITR_STICKY_EN for the sticky sequence.
module tb_masked_vec_irq_ctrl;

  logic clk;
  logic clr;
  int   tests_run;
  int   tests_failed;

  masked_vec_irq_ctrl_if #(.AW(8)) bus ();

  masked_vec_irq_ctrl dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  typedef struct {
    logic       itr_clr;
    logic       itr_en;
    logic [3:0] itr_in;
    logic [3:0] mask_in;
    logic       exp_pending;
    logic [7:0] exp_pc;
    logic [3:0] exp_itr;
    logic [3:0] exp_mask;
  } vec_t;

  typedef struct {
    int         idx;
    logic       exp_pending;
    logic [7:0] exp_pc;
    logic [3:0] exp_itr;
    logic [3:0] exp_mask;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic c, input logic en,
                               input logic [3:0] itr, input logic [3:0] msk);
    bus.itr_clr = c;
    bus.itr_en  = en;
    bus.itr_in  = itr;
    bus.mask_in = msk;
  endtask

  task automatic checkAll(input string tag, input logic p, input logic [7:0] pc,
                          input logic [3:0] ir, input logic [3:0] mr);
    checkOutput({tag, ".i_pending"}, 32'(bus.i_pending), 32'(p));
    checkOutput({tag, ".pc_out"},    32'(bus.pc_out),    32'(pc));
    checkOutput({tag, ".itr_reg"},   32'(bus.itr_reg),   32'(ir));
    checkOutput({tag, ".mask_reg"},  32'(bus.mask_reg),  32'(mr));
  endtask

  initial begin
    sb_t e;
    tests_run    = 0;
    tests_failed = 0;
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);
    clr = 1'b1;

    // Table: clr, en, itr_in, mask_in -> pending, pc, itr_reg, mask_reg
    vecs.push_back('{1'b0, 1'b1, 4'b1000, 4'b1111, 1'b1, 8'd200, 4'b1000, 4'b1111});
    vecs.push_back('{1'b0, 1'b1, 4'b0110, 4'b1111, 1'b1, 8'd180, 4'b0110, 4'b1111});
    vecs.push_back('{1'b0, 1'b1, 4'b0110, 4'b1101, 1'b1, 8'd220, 4'b0110, 4'b1101});
    vecs.push_back('{1'b0, 1'b1, 4'b0001, 4'b1110, 1'b0, 8'd150, 4'b0001, 4'b1110});
    vecs.push_back('{1'b0, 1'b1, 4'b1111, 4'b1111, 1'b1, 8'd150, 4'b1111, 4'b1111});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'd150, 4'b1111, 4'b1111});
    vecs.push_back('{1'b1, 1'b1, 4'b1111, 4'b1111, 1'b0, 8'd150, 4'b0000, 4'b0000});
    vecs.push_back('{1'b0, 1'b1, 4'b1010, 4'b1010, 1'b1, 8'd180, 4'b1010, 4'b1010});
    vecs.push_back('{1'b0, 1'b1, 4'b1100, 4'b1000, 1'b1, 8'd200, 4'b1100, 4'b1000});
    vecs.push_back('{1'b0, 1'b1, 4'b0100, 4'b1111, 1'b1, 8'd220, 4'b0100, 4'b1111});

    // Reset state.
    #12;
    checkAll("reset", 1'b0, 8'd150, 4'h0, 4'h0);
    @(negedge clk);
    clr = 1'b0;

`ifndef ITR_STICKY_EN
    // Table-driven vectors through the scoreboard.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].itr_clr, vecs[i].itr_en, vecs[i].itr_in, vecs[i].mask_in);
      sb.push_back('{i, vecs[i].exp_pending, vecs[i].exp_pc,
                     vecs[i].exp_itr, vecs[i].exp_mask});
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        checkOutput("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        checkAll($sformatf("vec%0d", e.idx), e.exp_pending, e.exp_pc,
                 e.exp_itr, e.exp_mask);
      end
    end
`endif

    // Drop itr_en with a pending source: i_pending falls same cycle, regs hold.
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 4'h0, 4'h0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 4'b0010, 4'b1111);
    @(posedge clk);
    #1;
    checkAll("gate_pre", 1'b1, 8'd180, 4'b0010, 4'b1111);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 4'b1000, 4'b0000);
    #1;
    checkAll("gate_drop", 1'b0, 8'd180, 4'b0010, 4'b1111);
    @(posedge clk);
    #1;
    checkAll("gate_hold", 1'b0, 8'd180, 4'b0010, 4'b1111);

    // Async reset mid-cycle with all bits set, held across an edge with itr_en.
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 4'hF, 4'hF);
    @(posedge clk);
    #1;
    checkAll("preclr", 1'b1, 8'd150, 4'hF, 4'hF);
    #2;
    clr = 1'b1;
    #1;
    checkAll("clr_async", 1'b0, 8'd150, 4'h0, 4'h0);
    @(posedge clk);
    #1;
    checkAll("clr_held", 1'b0, 8'd150, 4'h0, 4'h0);
    @(negedge clk);
    clr = 1'b0;
    applyStimulus(1'b0, 1'b1, 4'b1000, 4'b1000);
    @(posedge clk);
    #1;
    checkAll("clr_resume", 1'b1, 8'd200, 4'b1000, 4'b1000);

`ifdef ITR_STICKY_EN
    // Sticky accumulation, then sync clear.
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 4'h0, 4'h0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 4'b0100, 4'b1111);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 4'b0001, 4'b1111);
    @(posedge clk);
    #1;
    checkAll("sticky_acc", 1'b1, 8'd150, 4'b0101, 4'b1111);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 4'h0, 4'b1111);
    @(posedge clk);
    #1;
    checkAll("sticky_clr", 1'b0, 8'd150, 4'h0, 4'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
